// File: rtl/shift_reg_param.sv
`default_nettype none
// ============================================================================
// shift_reg_param : WIDTH-bit universal/barrel shift register with an
//                   LSB-first full-duplex serial transfer engine.
// Revision        : 1.0
// ============================================================================
module shift_reg_param #(
  parameter int WIDTH = 8,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shamt,
  input  logic             ser_in,
  output logic [WIDTH-1:0] Q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam int c_cw = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [c_cw-1:0] c_last  = c_cw'(WIDTH - 1);
  localparam logic [SHW-1:0]  c_width = SHW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_q, w_q_nx;
  logic [c_cw-1:0]  r_cnt, w_cnt_nx;
  logic             r_busy, r_done;

  logic [SHW-1:0]   w_rot_amt;
  logic [WIDTH-1:0] w_asr, w_ror, w_rol;

  // Complementary shift of WIDTH-rot is WIDTH when rot=0, which yields zero
  assign w_rot_amt = shamt % c_width;
  assign w_ror     = (r_q >> w_rot_amt) | (r_q << (c_width - w_rot_amt));
  assign w_rol     = (r_q << w_rot_amt) | (r_q >> (c_width - w_rot_amt));
  assign w_asr     = $signed(r_q) >>> shamt;

  always_comb begin
    w_state_nx = r_state;
    w_q_nx     = r_q;
    w_cnt_nx   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (en) begin
          case (ctrl)
            4'd0: w_q_nx = '0;
            4'd1: w_q_nx = data_in;
            4'd2: w_q_nx = r_q >> shamt;
            4'd3: w_q_nx = r_q << shamt;
            4'd4: w_q_nx = w_asr;
            4'd5: w_q_nx = {ser_in, r_q[WIDTH-1:1]};
            4'd6: w_q_nx = w_ror;
            4'd7: w_q_nx = w_rol;
            4'd8: w_q_nx = {r_q[WIDTH-2:0], ser_in};
            4'd9: begin
              w_q_nx     = data_in;
              w_cnt_nx   = '0;
              w_state_nx = S_SHIFT;
            end
            default: w_q_nx = r_q;
          endcase
        end
      end
      S_SHIFT: begin
        if (en) begin
          w_q_nx = {ser_in, r_q[WIDTH-1:1]};
          if (r_cnt == c_last) begin
            w_cnt_nx   = '0;
            w_state_nx = S_DONE;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_q     <= w_q_nx;
      r_cnt   <= w_cnt_nx;
      r_busy  <= (w_state_nx == S_SHIFT);
      r_done  <= (w_state_nx == S_DONE);
    end
  end

  assign Q       = r_q;
  assign ser_out = r_q[0];
  assign busy    = r_busy;
  assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_param.sv
`default_nettype none
// ============================================================================
// tb_shift_reg_param : directed vector bench for shift_reg_param (WIDTH=8).
// Revision           : 1.0
// ============================================================================
module tb_shift_reg_param;

  localparam int WIDTH = 8;
  localparam int SHW   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [3:0]       ctrl;
  logic [WIDTH-1:0] data_in;
  logic [SHW-1:0]   shamt;
  logic             ser_in;
  logic [WIDTH-1:0] Q;
  logic             ser_out;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  shift_reg_param #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .ctrl    (ctrl),
    .data_in (data_in),
    .shamt   (shamt),
    .ser_in  (ser_in),
    .Q       (Q),
    .ser_out (ser_out),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [3:0] ctrl;
    logic [7:0] din;
    logic [3:0] sh;
    logic       si;
    logic [7:0] exp_q;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Runs one transfer of 0xA5 with ser_in pattern 1,1,0,0,0,0,1,1 (LSB first).
  // pause_after: drop en for 3 cycles after that many shifts (-1 = none).
  // rst_after: assert async reset after that many shifts (-1 = none).
  task automatic run_xfer(input string tag, input int pause_after, input int rst_after,
                          input logic [3:0] ctrl_during);
    logic [7:0] din_v;
    logic [7:0] si_v;
    logic [7:0] q_hold;
    int         busy_cnt;
    din_v    = 8'hA5;
    si_v     = 8'b1100_0011;  // bit k is the k-th sampled ser_in
    busy_cnt = 0;
    ctrl = 4'd9; data_in = din_v; en = 1'b1; ser_in = 1'b0;
    @(negedge clk);
    chk({tag, "_start_q"}, Q, din_v);
    ctrl = ctrl_during; data_in = 8'h00;
    for (int k = 0; k < WIDTH; k++) begin
      if (k == rst_after) begin
        #2 rst = 1'b1;
        #1;
        chk({tag, "_rst_q"}, Q, 8'h00);
        chk({tag, "_rst_busy"}, busy, 1'b0);
        chk({tag, "_rst_done"}, done, 1'b0);
        rst = 1'b0; en = 1'b0;
        @(negedge clk);
        chk({tag, "_post_rst_done"}, done, 1'b0);
        chk({tag, "_post_rst_busy"}, busy, 1'b0);
        chk({tag, "_post_rst_q"}, Q, 8'h00);
        return;
      end
      if (k == pause_after) begin
        q_hold = Q;
        en = 1'b0;
        for (int p = 0; p < 3; p++) begin
          @(negedge clk);
          if (busy === 1'b1) busy_cnt++;
          chk({tag, "_pause_q"}, Q, q_hold);
          chk({tag, "_pause_ser_out"}, ser_out, din_v[k]);
          chk({tag, "_pause_busy"}, busy, 1'b1);
        end
      end
      chk({tag, "_ser_out"}, ser_out, din_v[k]);
      chk({tag, "_busy_no_done"}, done, 1'b0);
      if (busy === 1'b1) busy_cnt++;
      en = 1'b1; ser_in = si_v[k];
      @(negedge clk);
    end
    chk({tag, "_done_pulse"}, done, 1'b1);
    chk({tag, "_done_busy"}, busy, 1'b0);
    chk({tag, "_final_q"}, Q, 8'hC3);
    chk({tag, "_busy_cycles"}, busy_cnt, WIDTH + ((pause_after >= 0) ? 3 : 0));
    ctrl = 4'd0; en = 1'b1;   // DONE must ignore this clear
    @(negedge clk);
    chk({tag, "_done_once"}, done, 1'b0);
    chk({tag, "_idle_busy"}, busy, 1'b0);
    chk({tag, "_idle_q"}, Q, 8'hC3);
    en = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 4'd1,  8'hB4, 4'd0,  1'b0, 8'hB4};
    vecs[1]  = '{1'b1, 4'd4,  8'h00, 4'd2,  1'b0, 8'hED};
    vecs[2]  = '{1'b1, 4'd1,  8'hB4, 4'd0,  1'b0, 8'hB4};
    vecs[3]  = '{1'b1, 4'd2,  8'h00, 4'd2,  1'b0, 8'h2D};
    vecs[4]  = '{1'b1, 4'd1,  8'hFF, 4'd0,  1'b0, 8'hFF};
    vecs[5]  = '{1'b1, 4'd3,  8'h00, 4'd8,  1'b0, 8'h00};
    vecs[6]  = '{1'b1, 4'd1,  8'h80, 4'd0,  1'b0, 8'h80};
    vecs[7]  = '{1'b1, 4'd4,  8'h00, 4'd15, 1'b0, 8'hFF};
    vecs[8]  = '{1'b1, 4'd1,  8'h81, 4'd0,  1'b0, 8'h81};
    vecs[9]  = '{1'b1, 4'd7,  8'h00, 4'd3,  1'b0, 8'h0C};
    vecs[10] = '{1'b1, 4'd1,  8'h81, 4'd0,  1'b0, 8'h81};
    vecs[11] = '{1'b1, 4'd6,  8'h00, 4'd9,  1'b0, 8'hC0};
    vecs[12] = '{1'b1, 4'd0,  8'hAA, 4'd0,  1'b0, 8'h00};
    vecs[13] = '{1'b1, 4'd8,  8'h00, 4'd5,  1'b1, 8'h01};
    vecs[14] = '{1'b1, 4'd8,  8'h00, 4'd5,  1'b1, 8'h03};
    vecs[15] = '{1'b1, 4'd5,  8'h00, 4'd5,  1'b1, 8'h81};
    vecs[16] = '{1'b1, 4'd4,  8'h00, 4'd0,  1'b0, 8'h81};
    vecs[17] = '{1'b1, 4'd7,  8'h00, 4'd8,  1'b0, 8'h81};
    vecs[18] = '{1'b0, 4'd1,  8'h3C, 4'd0,  1'b0, 8'h81};
    vecs[19] = '{1'b1, 4'd12, 8'h3C, 4'd0,  1'b0, 8'h81};
    vecs[20] = '{1'b1, 4'd2,  8'h00, 4'd9,  1'b0, 8'h00};

    rst = 1'b1; en = 1'b0; ctrl = 4'd0; data_in = '0; shamt = '0; ser_in = 1'b0;
    #1;
    chk("reset_q", Q, 8'h00);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_ser_out", ser_out, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 21; i++) begin
      en = vecs[i].en; ctrl = vecs[i].ctrl; data_in = vecs[i].din;
      shamt = vecs[i].sh; ser_in = vecs[i].si;
      @(negedge clk);
      chk($sformatf("vec%0d_q", i), Q, vecs[i].exp_q);
      chk($sformatf("vec%0d_busy", i), busy, 1'b0);
      chk($sformatf("vec%0d_done", i), done, 1'b0);
    end
    en = 1'b0;

    // Asynchronous reset between edges from a non-zero value
    ctrl = 4'd1; data_in = 8'hFF; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    chk("pre_async_q", Q, 8'hFF);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_q", Q, 8'h00);
    chk("async_rst_ser_out", ser_out, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    run_xfer("xfer", -1, -1, 4'd1);
    run_xfer("xfer_pause", 4, -1, 4'd0);
    run_xfer("xfer_rst", -1, 5, 4'd0);

    // Enable gating in IDLE after the aborted transfer
    en = 1'b0; ctrl = 4'd1; data_in = 8'h3C;
    @(negedge clk);
    chk("idle_en0_q", Q, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
